// File: rtl/atm_pin_session_ctrl.sv
// Purpose : one PIN attempt per card session, driving the X/Y unlock detector.
// Latency : key accepted -> detector strobe next cycle; last strobe -> session/fail two cycles later.
// Backpressure : key_ready is low outside ENTRY; keys offered while it is low are dropped silently.
//
// Ports:
//   clk, rst (async, active low)        - clock and reset
//   card_in, cancel                     - card present / customer cancel levels
//   key_valid, key_sym, key_ready       - keypad symbol handshake (1 = X, 0 = Y)
//   det_x, det_y, det_rst_n, det_unlock - unlock detector strobes, reset and result
//   session_active, attempt_fail,
//   card_retain, tries_left             - session status towards the host
//
// Optional feature: define ATM_PIN_TIMEOUT_EN to fail an attempt after TIMEOUT_CYC idle
// cycles in ENTRY. Without it ENTRY waits indefinitely.
module atm_pin_session_ctrl #(
    parameter int PIN_LEN     = 5,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       card_in,
    input  logic       cancel,
    input  logic       key_valid,
    input  logic       key_sym,
    output logic       key_ready,
    output logic       det_x,
    output logic       det_y,
    output logic       det_rst_n,
    input  logic       det_unlock,
    output logic       session_active,
    output logic       attempt_fail,
    output logic       card_retain,
    output logic [3:0] tries_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ENTRY   = 3'd2,
        CHECK   = 3'd3,
        SESSION = 3'd4,
        LOCKED  = 3'd5
    } state_t;

    localparam int              CW         = $clog2(PIN_LEN + 1);
    localparam logic [CW-1:0]   LAST_SYM   = CW'(PIN_LEN - 1);
    localparam logic [3:0]      TRIES_INIT = 4'(MAX_TRIES);

    state_t        state;
    logic [CW-1:0] sym_cnt;
    logic          hit;
    logic          check_cnt;   // 0 = first CHECK cycle, 1 = decision cycle

    logic          key_acc;
    logic [3:0]    tries_dec;
    logic          timeout;
    logic          check_fail;
    logic          fail_now;

    assign key_acc   = key_valid & key_ready;
    assign tries_dec = (tries_left == 4'd0) ? 4'd0 : tries_left - 4'd1;

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);

    logic [TW-1:0] timer;

    // Runs only in ENTRY; restarts on every accepted key so the limit is per-key inactivity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state != ENTRY || key_acc) begin
            timer <= '0;
        end else if (!timeout) begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout = (state == ENTRY) && (timer == TIMER_MAX);
`else
    // No inactivity limit; the term only keeps the parameter referenced.
    assign timeout = 1'b0 && (TIMEOUT_CYC == 0);
`endif

    // The detector result is taken live in the decision cycle as well as from the sticky flag,
    // because the final strobe only becomes visible as det_unlock in that same cycle.
    assign check_fail = (state == CHECK) && check_cnt && !(hit || det_unlock);
    assign fail_now   = check_fail || timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            det_x          <= 1'b0;
            det_y          <= 1'b0;
            det_rst_n      <= 1'b0;
            key_ready      <= 1'b0;
            session_active <= 1'b0;
            attempt_fail   <= 1'b0;
            card_retain    <= 1'b0;
            tries_left     <= TRIES_INIT;
            sym_cnt        <= '0;
            hit            <= 1'b0;
            check_cnt      <= 1'b0;
        end else begin
            // Strobes and the fail flag are single-cycle pulses.
            det_x        <= 1'b0;
            det_y        <= 1'b0;
            attempt_fail <= 1'b0;

            if ((state == ENTRY || state == CHECK) && det_unlock) begin
                hit <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tries_left     <= TRIES_INIT;
                    session_active <= 1'b0;
                    key_ready      <= 1'b0;
                    if (card_in) begin
                        state     <= CLEAR;
                        det_rst_n <= 1'b0;
                    end else begin
                        det_rst_n <= 1'b1;
                    end
                end

                CLEAR, ENTRY, CHECK: begin
                    if (!card_in || cancel) begin
                        // Abandoned attempt: not counted, tries_left reloads in IDLE.
                        state     <= IDLE;
                        key_ready <= 1'b0;
                        det_rst_n <= 1'b1;
                    end else if (fail_now) begin
                        attempt_fail <= 1'b1;
                        tries_left   <= tries_dec;
                        key_ready    <= 1'b0;
                        if (tries_dec == 4'd0) begin
                            state       <= LOCKED;
                            card_retain <= 1'b1;
                        end else begin
                            // Retry always goes through CLEAR so the detector restarts idle.
                            state     <= CLEAR;
                            det_rst_n <= 1'b0;
                        end
                    end else begin
                        case (state)
                            CLEAR: begin
                                det_rst_n <= 1'b1;
                                sym_cnt   <= '0;
                                hit       <= 1'b0;
                                check_cnt <= 1'b0;
                                key_ready <= 1'b1;
                                state     <= ENTRY;
                            end
                            ENTRY: begin
                                if (key_acc) begin
                                    det_x   <= key_sym;
                                    det_y   <= ~key_sym;
                                    sym_cnt <= sym_cnt + 1'b1;
                                    if (sym_cnt == LAST_SYM) begin
                                        key_ready <= 1'b0;
                                        check_cnt <= 1'b0;
                                        state     <= CHECK;
                                    end
                                end
                            end
                            CHECK: begin
                                check_cnt <= 1'b1;
                                // Failures were handled above; reaching here in the
                                // decision cycle means the detector unlocked.
                                if (check_cnt) begin
                                    session_active <= 1'b1;
                                    state          <= SESSION;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                SESSION: begin
                    if (!card_in || cancel) begin
                        session_active <= 1'b0;
                        state          <= IDLE;
                    end
                end

                LOCKED: begin
                    // Terminal until reset.
                    key_ready   <= 1'b0;
                    card_retain <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_pin_session_ctrl.sv
// Directed testbench for atm_pin_session_ctrl with a behavioural 5-symbol detector
// that unlocks on Y,Y,X,Y,X (X = 1) after its own reset.
module tb_atm_pin_session_ctrl;

    logic       clk;
    logic       rst;
    logic       card_in;
    logic       cancel;
    logic       key_valid;
    logic       key_sym;
    logic       key_ready;
    logic       det_x;
    logic       det_y;
    logic       det_rst_n;
    logic       det_unlock;
    logic       session_active;
    logic       attempt_fail;
    logic       card_retain;
    logic [3:0] tries_left;

    int n_cmp;
    int n_bad;

    localparam logic [4:0] GOOD_PIN = 5'b00101;   // Y,Y,X,Y,X oldest first (bit 4)
    localparam logic [4:0] BAD_PIN  = 5'b01001;   // Y,X,Y,Y,X

    atm_pin_session_ctrl #(
        .PIN_LEN    (5),
        .MAX_TRIES  (3),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .card_in       (card_in),
        .cancel        (cancel),
        .key_valid     (key_valid),
        .key_sym       (key_sym),
        .key_ready     (key_ready),
        .det_x         (det_x),
        .det_y         (det_y),
        .det_rst_n     (det_rst_n),
        .det_unlock    (det_unlock),
        .session_active(session_active),
        .attempt_fail  (attempt_fail),
        .card_retain   (card_retain),
        .tries_left    (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model: shift register of strobed symbols, sticky unlock on match.
    logic [4:0] det_sh;
    logic [2:0] det_cnt;
    always @(posedge clk) begin
        if (!det_rst_n) begin
            det_sh     <= 5'd0;
            det_cnt    <= 3'd0;
            det_unlock <= 1'b0;
        end else if (det_x || det_y) begin
            det_sh <= {det_sh[3:0], det_x};
            if (det_cnt != 3'd7) det_cnt <= det_cnt + 3'd1;
            if ({det_sh[3:0], det_x} == GOOD_PIN && det_cnt >= 3'd4) det_unlock <= 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic sym);
        key_valid = 1'b1;
        key_sym   = sym;
        tick();
    endtask

    task automatic card_out;
        card_in   = 1'b0;
        key_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0; card_in = 1'b0; cancel = 1'b0; key_valid = 1'b0; key_sym = 1'b0;
        tick(); tick();
        n_cmp++; if (det_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_det_rst_n got %b want 0", det_rst_n); end
        n_cmp++; if ({det_x, det_y} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes got %b want 00", {det_x, det_y}); end
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL rst_key_ready got %b want 0", key_ready); end
        n_cmp++; if ({session_active, attempt_fail, card_retain} !== 3'b000) begin n_bad++; $display("FAIL rst_status got %b want 000", {session_active, attempt_fail, card_retain}); end
        n_cmp++; if (tries_left !== 4'd3) begin n_bad++; $display("FAIL rst_tries got %0d want 3", tries_left); end
        rst = 1'b1;
        tick();
        n_cmp++; if (det_rst_n !== 1'b1) begin n_bad++; $display("FAIL rel_det_rst_n got %b want 1", det_rst_n); end
    endtask

    task automatic test_unlock;
        logic [4:0] seq;
        seq = GOOD_PIN;
        card_in = 1'b1;
        tick();
        n_cmp++; if (det_rst_n !== 1'b0) begin n_bad++; $display("FAIL unl_clear got %b want 0", det_rst_n); end
        tick();
        n_cmp++; if ({det_rst_n, key_ready} !== 2'b11) begin n_bad++; $display("FAIL unl_entry got %b want 11", {det_rst_n, key_ready}); end
        for (int i = 4; i >= 0; i--) begin
            press(seq[i]);
            n_cmp++; if ({det_x, det_y} !== {seq[i], ~seq[i]}) begin n_bad++; $display("FAIL unl_strobe%0d got %b want %b", 4 - i, {det_x, det_y}, {seq[i], ~seq[i]}); end
        end
        key_valid = 1'b0;
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL unl_check_ready got %b want 0", key_ready); end
        tick();
        n_cmp++; if ({session_active, det_x, det_y} !== 3'b000) begin n_bad++; $display("FAIL unl_check2 got %b want 000", {session_active, det_x, det_y}); end
        tick();
        n_cmp++; if (session_active !== 1'b1) begin n_bad++; $display("FAIL unl_session got %b want 1", session_active); end
        n_cmp++; if (tries_left !== 4'd3) begin n_bad++; $display("FAIL unl_tries got %0d want 3", tries_left); end
        card_in = 1'b0;
        tick();
        n_cmp++; if (session_active !== 1'b0) begin n_bad++; $display("FAIL unl_drop got %b want 0", session_active); end
        tick();
    endtask

    task automatic test_retry;
        logic [4:0] seq;
        seq = BAD_PIN;
        card_in = 1'b1;
        tick(); tick();
        for (int i = 4; i >= 0; i--) press(seq[i]);
        key_valid = 1'b0;
        tick();
        n_cmp++; if (attempt_fail !== 1'b0) begin n_bad++; $display("FAIL rty_early_fail got %b want 0", attempt_fail); end
        tick();
        n_cmp++; if ({attempt_fail, det_rst_n, session_active} !== 3'b100) begin n_bad++; $display("FAIL rty_fail got %b want 100", {attempt_fail, det_rst_n, session_active}); end
        n_cmp++; if (tries_left !== 4'd2) begin n_bad++; $display("FAIL rty_tries got %0d want 2", tries_left); end
        tick();
        n_cmp++; if ({attempt_fail, key_ready, det_rst_n} !== 3'b011) begin n_bad++; $display("FAIL rty_reentry got %b want 011", {attempt_fail, key_ready, det_rst_n}); end
        seq = GOOD_PIN;
        for (int i = 4; i >= 0; i--) press(seq[i]);
        key_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (session_active !== 1'b1) begin n_bad++; $display("FAIL rty_session got %b want 1", session_active); end
        n_cmp++; if (tries_left !== 4'd2) begin n_bad++; $display("FAIL rty_tries_kept got %0d want 2", tries_left); end
        card_out();
        n_cmp++; if (tries_left !== 4'd3) begin n_bad++; $display("FAIL rty_reload got %0d want 3", tries_left); end
    endtask

    task automatic test_card_pull;
        logic [4:0] seq;
        seq = BAD_PIN;
        card_in = 1'b1;
        tick(); tick();
        for (int i = 4; i >= 0; i--) press(seq[i]);
        key_valid = 1'b0;
        tick(); tick(); tick();   // fail, CLEAR, ENTRY
        press(1'b0); press(1'b0); press(1'b1);
        key_valid = 1'b0;
        card_in = 1'b0;
        tick();
        n_cmp++; if ({attempt_fail, key_ready} !== 2'b00) begin n_bad++; $display("FAIL pull_nofail got %b want 00", {attempt_fail, key_ready}); end
        n_cmp++; if (tries_left !== 4'd2) begin n_bad++; $display("FAIL pull_tries_kept got %0d want 2", tries_left); end
        tick();
        n_cmp++; if (tries_left !== 4'd3) begin n_bad++; $display("FAIL pull_reload got %0d want 3", tries_left); end
        seq = GOOD_PIN;
        card_in = 1'b1;
        tick(); tick();
        for (int i = 4; i >= 0; i--) press(seq[i]);
        key_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (session_active !== 1'b1) begin n_bad++; $display("FAIL pull_session got %b want 1", session_active); end
        card_out();
    endtask

    task automatic test_cancel;
        card_in = 1'b1;
        tick(); tick();
        press(1'b0); press(1'b1);
        cancel    = 1'b1;
        key_valid = 1'b1;
        key_sym   = 1'b1;
        tick();
        n_cmp++; if ({key_ready, det_x, det_y} !== 3'b000) begin n_bad++; $display("FAIL cancel_idle got %b want 000", {key_ready, det_x, det_y}); end
        cancel    = 1'b0;
        key_valid = 1'b0;
        tick();
        n_cmp++; if ({det_rst_n, attempt_fail} !== 2'b00) begin n_bad++; $display("FAIL cancel_restart got %b want 00", {det_rst_n, attempt_fail}); end
        card_out();
    endtask

    task automatic test_lockout;
        logic [4:0] seq;
        logic       seen;
        seq = BAD_PIN;
        card_in = 1'b1;
        tick(); tick();
        for (int a = 0; a < 3; a++) begin
            for (int i = 4; i >= 0; i--) press(seq[i]);
            tick();   // key_valid still held through CHECK
            n_cmp++; if ({det_x, det_y} !== 2'b00) begin n_bad++; $display("FAIL lock_check_key%0d got %b want 00", a, {det_x, det_y}); end
            tick();
            n_cmp++; if (attempt_fail !== 1'b1) begin n_bad++; $display("FAIL lock_fail%0d got %b want 1", a, attempt_fail); end
            n_cmp++; if (tries_left !== 4'(2 - a)) begin n_bad++; $display("FAIL lock_tries%0d got %0d want %0d", a, tries_left, 2 - a); end
            key_valid = 1'b0;
            if (a < 2) tick();
        end
        n_cmp++; if ({card_retain, key_ready} !== 2'b10) begin n_bad++; $display("FAIL lock_retain got %b want 10", {card_retain, key_ready}); end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            key_valid = 1'b1;
            key_sym   = c[0];
            card_in   = c[1];
            cancel    = c[2];
            tick();
            seen = seen | det_x | det_y | attempt_fail | session_active | key_ready;
        end
        key_valid = 1'b0; card_in = 1'b0; cancel = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL lock_ignored got %b want 0", seen); end
        n_cmp++; if ({card_retain, tries_left} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL lock_held got %b want 10000", {card_retain, tries_left}); end
        rst = 1'b0;
        #2;
        n_cmp++; if ({card_retain, tries_left, det_rst_n} !== {1'b1 ^ 1'b1, 4'd3, 1'b0}) begin n_bad++; $display("FAIL lock_async_rst got %b want 000110", {card_retain, tries_left, det_rst_n}); end
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (card_retain !== 1'b0) begin n_bad++; $display("FAIL lock_cleared got %b want 0", card_retain); end
    endtask

    task automatic test_timeout;
        int  n;
        logic fired;
        card_in = 1'b1;
        tick(); tick();
        press(1'b0); press(1'b0);
        key_valid = 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
        n = 0;
        fired = 1'b0;
        while (!fired && n < 40) begin
            tick();
            n++;
            fired = attempt_fail;
        end
        n_cmp++; if (n !== 21) begin n_bad++; $display("FAIL timeout_cycles got %0d want 21", n); end
        n_cmp++; if (tries_left !== 4'd2) begin n_bad++; $display("FAIL timeout_tries got %0d want 2", tries_left); end
`else
        n = 0;
        fired = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            fired = fired | attempt_fail;
            n++;
        end
        n_cmp++; if (fired !== 1'b0) begin n_bad++; $display("FAIL no_timeout_fail got %b want 0 after %0d cycles", fired, n); end
        n_cmp++; if ({key_ready, tries_left} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL no_timeout_wait got %b want 10011", {key_ready, tries_left}); end
`endif
        card_out();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_unlock();
        test_retry();
        test_card_pull();
        test_cancel();
        test_timeout();
        test_lockout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atm_pin_session_ctrl.md
Name: atm_pin_session_ctrl

Overview:
Sequences one PIN attempt per card session through the 5-symbol X/Y unlock sequence detector. It converts accepted keypad symbols into single-cycle X/Y strobes for the detector and clears the detector between attempts. It counts failed attempts, retains the card after MAX_TRIES failures, and opens a customer session on success. It sits between the card reader/keypad front end and the unlock detector.

Parameters:
PIN_LEN, 5, symbols per attempt (>=1)
MAX_TRIES, 3, failed attempts before card retention (1..15)
TIMEOUT_CYC, 1000, inactivity cycles in ENTRY before an attempt is counted failed (used only with TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
card_in  input  1  card present level
cancel  input  1  customer cancel level
key_valid  input  1  keypad symbol valid, one cycle per key
key_sym  input  1  1 = X symbol, 0 = Y symbol
key_ready  output  1  key accepted this cycle when key_valid & key_ready
det_x  output  1  X strobe to detector, registered
det_y  output  1  Y strobe to detector, registered
det_rst_n  output  1  detector reset, active low, registered
det_unlock  input  1  detector unlock flag
session_active  output  1  session granted
attempt_fail  output  1  one-cycle pulse per failed attempt
card_retain  output  1  card retained, lockout
tries_left  output  4  remaining attempts

Behaviour:
- Single clock clk. rst is asynchronous and active-low. All outputs are registered.
- Reset values: state IDLE, det_x=0, det_y=0, det_rst_n=0, key_ready=0, session_active=0, attempt_fail=0, card_retain=0, tries_left=MAX_TRIES, sym_cnt=0, hit=0.
- det_rst_n goes to 1 on the first clk edge after reset release.
- States: IDLE, CLEAR, ENTRY, CHECK, SESSION, LOCKED.
- IDLE
  - card_in=1 -> CLEAR.
  - tries_left is loaded with MAX_TRIES.
- CLEAR
  - det_rst_n=0 for exactly 1 cycle.
  - sym_cnt=0, hit=0, timer=0.
  - Next state is ENTRY.
- ENTRY
  - key_ready=1 while sym_cnt<PIN_LEN.
  - On an accepted key, the next cycle drives det_x=key_sym and det_y=~key_sym for exactly 1 cycle. Otherwise det_x=det_y=0.
  - Never both high.
  - Back-to-back keys are accepted every cycle.
  - sym_cnt increments per accepted key. When the PIN_LEN-th key is accepted -> CHECK.
- hit is sticky: set on any cycle det_unlock=1 in ENTRY or CHECK.
- CHECK
  - Lasts exactly 2 cycles so the final strobe registers and det_unlock is visible. key_ready=0.
  - At the end: hit=1 -> SESSION.
  - Otherwise it is a fail: attempt_fail pulses 1 cycle and tries_left decrements (saturates at 0).
  - After a fail: new tries_left=0 -> LOCKED, else -> CLEAR.
- SESSION
  - session_active=1.
  - card_in=0 or cancel=1 -> IDLE, and session_active drops the following cycle.
- LOCKED
  - card_retain=1, key_ready=0.
  - All inputs are ignored. Exits only on rst.
- Priority in CLEAR/ENTRY/CHECK, highest first: card_in=0 -> IDLE (no fail counted, tries_left kept until the next IDLE load), then cancel=1 -> IDLE, then timeout, then key.
- Keys presented while key_ready=0 are dropped silently and never strobe the detector.
- A failed attempt always passes through CLEAR, so the detector always starts each attempt from its idle state.
- Reset mid-operation returns to the reset values immediately. The detector is held reset by det_rst_n=0.

Optional Feature:
- Macro ATM_PIN_TIMEOUT_EN.
- Defined:
  - A timer of width $clog2(TIMEOUT_CYC+1) counts cycles in ENTRY.
  - It clears on entering ENTRY and on each accepted key.
  - When it reaches TIMEOUT_CYC it is treated as a failed attempt, same path as a CHECK fail.
- Undefined: there is no timer and ENTRY waits indefinitely.

Test Plan:
- Reset, then card_in=1, keys Y,Y,X,Y,X back-to-back -> det_rst_n low 1 cycle, strobes det_y,det_y,det_x,det_y,det_x in consecutive cycles, session_active=1 two cycles after the last strobe, tries_left=3.
- Card in, keys Y,X,Y,Y,X -> attempt_fail pulse, tries_left=2, CLEAR pulse on det_rst_n. Then the correct sequence -> session_active=1.
- Three wrong attempts -> three attempt_fail pulses, tries_left=0, card_retain=1. Further keys produce no det_x/det_y, and only rst clears the lockout.
- card_in dropped after 3 keys -> IDLE, no attempt_fail. Re-insert -> tries_left reloads to 3 and a full correct sequence unlocks.
- key_valid held during CHECK and LOCKED -> no strobes. Cancel during ENTRY -> IDLE within 1 cycle.
- With ATM_PIN_TIMEOUT_EN, TIMEOUT_CYC=20: enter 2 keys then idle 20 cycles -> attempt_fail, tries_left=2. Without the macro: no fail after 100 idle cycles.
